// File: rtl/hornet_wb_pkg.sv
// Shared Hornet Wishbone definitions: bus widths, UART register map, TX FSM states, STATUS layout.
package hornet_wb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    // Register word offsets, decoded from wb_adr_i[3:2]
    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;
    localparam logic [1:0] UART_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned STAT_COUNT_W   = 4;

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone pipelined slave bus bundle; signal suffixes are from the slave's point of view.
interface wb_uart_tx_if;
    import hornet_wb_pkg::*;

    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic [WB_AW-1:0] wb_adr_i;
    logic [WB_DW-1:0] wb_dat_i;
    logic [WB_SW-1:0] wb_sel_i;
    logic             wb_stall_o;
    logic             wb_ack_o;
    logic [WB_DW-1:0] wb_dat_o;
    logic             wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign rd_data_c = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop cancel out
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone slave UART transmitter: TX FIFO, 8N1 serialiser, FIFO-empty interrupt.
module wb_uart_tx
    import hornet_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h0000_8020,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] BAUDDIV_RST = 16'd867
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    wb_uart_tx_if.slave  bus,
    output logic         tx_o,
    output logic         irq_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_e     state;
    logic [15:0]        baud_cnt;
    logic [7:0]         shift_q;
    logic [2:0]         bit_idx;
    logic               bit_end;

    logic [15:0]        bauddiv;
    logic               tx_en;
    logic               irq_en;

    logic               ack_q;
    logic               err_q;
    logic [WB_DW-1:0]   dat_q;
    logic [WB_DW-1:0]   rd_data;

    logic               req;
    logic [1:0]         reg_sel;
    logic               misaligned;
    logic               bus_err;
    logic               bus_ok;
    logic               push;
    logic               pop;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [7:0]         fifo_rd_data;

    logic               unused_ok;

    // Request decode; the interconnect has already matched the upper address bits
    assign req        = bus.wb_cyc_i & bus.wb_stb_i;
    assign reg_sel    = bus.wb_adr_i[3:2];
    assign misaligned = (bus.wb_adr_i[1:0] != 2'b00);
    assign bus_err    = req & (misaligned |
                               (bus.wb_we_i & (reg_sel == UART_TXDATA) & fifo_full));
    assign bus_ok     = req & ~bus_err;
    assign push       = bus_ok & bus.wb_we_i & (reg_sel == UART_TXDATA) & bus.wb_sel_i[0];
    assign pop        = (state == IDLE) & tx_en & ~fifo_empty;
    assign bit_end    = (baud_cnt == 16'd0);

    assign bus.wb_stall_o = 1'b0;
    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_err_o   = err_q;
    assign bus.wb_dat_o   = dat_q;

    assign unused_ok = ^{BASE_ADR, bus.wb_adr_i[WB_AW-1:4], bus.wb_dat_i[WB_DW-1:16],
                         bus.wb_sel_i[WB_SW-1:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .push      (push),
        .wr_data   (bus.wb_dat_i[7:0]),
        .pop       (pop),
        .rd_data_c (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Register read mux
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            UART_STATUS: begin
                rd_data[STAT_BUSY]  = (state != IDLE);
                rd_data[STAT_FULL]  = fifo_full;
                rd_data[STAT_EMPTY] = fifo_empty;
                rd_data[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
            end
            UART_BAUDDIV: rd_data[15:0] = bauddiv;
            UART_CTRL:    rd_data[1:0]  = {irq_en, tx_en};
            default:      rd_data = '0;
        endcase
    end

    // Bus response, register writes and interrupt
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            bauddiv <= BAUDDIV_RST;
            tx_en   <= 1'b0;
            irq_en  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            ack_q <= bus_ok;
            err_q <= bus_err;
            dat_q <= (bus_ok & ~bus.wb_we_i) ? rd_data : '0;
            if (bus_ok && bus.wb_we_i) begin
                case (reg_sel)
                    UART_BAUDDIV: begin
                        if (bus.wb_sel_i[0]) bauddiv[7:0]  <= bus.wb_dat_i[7:0];
                        if (bus.wb_sel_i[1]) bauddiv[15:8] <= bus.wb_dat_i[15:8];
                    end
                    UART_CTRL: begin
                        if (bus.wb_sel_i[0]) begin
                            tx_en  <= bus.wb_dat_i[0];
                            irq_en <= bus.wb_dat_i[1];
                        end
                    end
                    default: ;
                endcase
            end
            irq_o <= irq_en & fifo_empty & (state == IDLE);
        end
    end

    // 8N1 serialiser; each bit lasts bauddiv+1 clocks, divider resampled at every bit boundary
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            shift_q  <= '0;
            bit_idx  <= '0;
            tx_o     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        shift_q  <= fifo_rd_data;
                        baud_cnt <= bauddiv;
                        bit_idx  <= 3'd0;
                        state    <= START;
                        tx_o     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= bauddiv;
                        state    <= DATA;
                        tx_o     <= shift_q[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= bauddiv;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift_q[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: behavioural model compared every cycle plus directed literal checks.
module tb_wb_uart_tx;
    import hornet_wb_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_TXDATA  = 32'h0000_8020;
    localparam logic [31:0] A_STATUS  = 32'h0000_8024;
    localparam logic [31:0] A_BAUDDIV = 32'h0000_8028;
    localparam logic [31:0] A_CTRL    = 32'h0000_802C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic irq;

    wb_uart_tx_if bus();

    wb_uart_tx #(
        .BASE_ADR    (32'h0000_8020),
        .FIFO_DEPTH  (DEPTH),
        .BAUDDIV_RST (16'd867)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave),
        .tx_o     (tx),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  q[$];
    logic        m_tx_en, m_irq_en;
    logic [15:0] m_baud;
    logic        m_active;
    logic [7:0]  m_byte;
    int          m_bit, m_elapsed, m_len;
    logic        e_tx, e_irq, e_ack, e_err;
    logic [31:0] e_dat;
    logic        m_valid = 1'b0;

    // Line level of frame bit k: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[3'(k - 1)];
    endfunction

    task automatic model_reset();
        q.delete();
        m_tx_en  = 1'b0;
        m_irq_en = 1'b0;
        m_baud   = 16'd867;
        m_active = 1'b0;
        m_byte   = 8'h00;
        m_bit = 0; m_elapsed = 0; m_len = 1;
        e_tx = 1'b1; e_irq = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_dat = 32'h0;
        m_valid = 1'b1;
    endtask

    task automatic model_step();
        logic        pre_active;
        int          pre_count;
        logic [1:0]  r;
        logic        bad;
        pre_active = m_active;
        pre_count  = q.size();
        e_irq = m_irq_en && (pre_count == 0) && !pre_active;
        // line timing
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == m_len) begin
                m_bit++;
                m_elapsed = 0;
                m_len = int'(m_baud) + 1;
                if (m_bit == 10) m_active = 1'b0;
            end
        end else if (m_tx_en && q.size() != 0) begin
            m_byte = q.pop_front();
            m_active = 1'b1;
            m_bit = 0; m_elapsed = 0;
            m_len = int'(m_baud) + 1;
        end
        e_tx = m_active ? frame_bit(m_byte, m_bit) : 1'b1;
        // bus
        e_ack = 1'b0; e_err = 1'b0; e_dat = 32'h0;
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
            r = bus.wb_adr_i[3:2];
            bad = (bus.wb_adr_i[1:0] != 2'b00) || (bus.wb_we_i && r == 2'd0 && pre_count == DEPTH);
            if (bad) e_err = 1'b1;
            else begin
                e_ack = 1'b1;
                if (bus.wb_we_i) begin
                    if (r == 2'd0 && bus.wb_sel_i[0]) q.push_back(bus.wb_dat_i[7:0]);
                    if (r == 2'd2) begin
                        if (bus.wb_sel_i[0]) m_baud[7:0]  = bus.wb_dat_i[7:0];
                        if (bus.wb_sel_i[1]) m_baud[15:8] = bus.wb_dat_i[15:8];
                    end
                    if (r == 2'd3 && bus.wb_sel_i[0]) begin
                        m_tx_en  = bus.wb_dat_i[0];
                        m_irq_en = bus.wb_dat_i[1];
                    end
                end else begin
                    if (r == 2'd1)
                        e_dat = (32'(pre_count) << 8) | (pre_count == DEPTH ? 32'd2 : 32'd0)
                              | (pre_count == 0 ? 32'd4 : 32'd0) | (pre_active ? 32'd1 : 32'd0);
                    else if (r == 2'd2) e_dat = {16'h0, m_baud};
                    else if (r == 2'd3) e_dat = {30'h0, m_irq_en, m_tx_en};
                end
            end
        end
    endtask

    // Model advances on the same edges as the DUT
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (!rst && m_valid) begin
            check("tx_o",       32'(tx),             32'(e_tx));
            check("irq_o",      32'(irq),            32'(e_irq));
            check("wb_ack_o",   32'(bus.wb_ack_o),   32'(e_ack));
            check("wb_err_o",   32'(bus.wb_err_o),   32'(e_err));
            check("wb_dat_o",   bus.wb_dat_o,        e_dat);
            check("wb_stall_o", 32'(bus.wb_stall_o), 32'h0);
        end
    end

    // ---------------- bus driver ----------------
    logic        a_ack, a_err;
    logic [31:0] a_dat;

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'h0;
    endtask

    task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                             input logic [3:0] sel);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr; bus.wb_dat_i = wd; bus.wb_sel_i = sel;
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] sel);
        @(negedge clk);
        bus_drive(we, adr, wd, sel);
        @(negedge clk);
        a_ack = bus.wb_ack_o; a_err = bus.wb_err_o; a_dat = bus.wb_dat_o;
        bus_idle();
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
        xfer(1'b1, adr, wd, 4'hF);
    endtask

    task automatic rd_expect(input string name, input logic [31:0] adr, input logic [31:0] exp);
        xfer(1'b0, adr, 32'h0, 4'hF);
        check({name, "_ack"}, 32'(a_ack), 32'h1);
        check({name, "_dat"}, a_dat, exp);
    endtask

    // ---------------- directed tests ----------------
    int   seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [3:0] win;
    logic found, prev;
    int   gap, offs;

    task automatic wait_fall(input string name);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (tx == 1'b0) found = 1'b1;
        end
        check(name, 32'(found), 32'h1);
    endtask

    initial begin
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        check("t1_tx_idle", 32'(tx), 32'h1);
        check("t1_irq", 32'(irq), 32'h0);
        rd_expect("t1_status", A_STATUS, 32'h0000_0004);

        // 2: single frame, 4 clocks per bit
        wr(A_BAUDDIV, 32'd3);
        wr(A_CTRL, 32'h1);
        wr(A_TXDATA, 32'hA5);
        wait_fall("t2_start_seen");
        for (int k = 0; k < 10; k++) begin
            win = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                win[j] = tx;
            end
            check($sformatf("t2_bit%0d", k), 32'(win), (seq[k] != 0) ? 32'hF : 32'h0);
        end
        @(negedge clk);
        check("t2_idle_after_40", 32'(tx), 32'h1);

        // 3: fill FIFO with tx disabled, ninth write errors
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) begin
            xfer(1'b1, A_TXDATA, 32'(8'h10 + i), 4'h1);
            check($sformatf("t3_ack%0d", i), 32'(a_ack), (i < 8) ? 32'h1 : 32'h0);
            check($sformatf("t3_err%0d", i), 32'(a_err), (i < 8) ? 32'h0 : 32'h1);
        end
        rd_expect("t3_status_full", A_STATUS, 32'h0000_0802);

        // drain quickly at 1 clock per bit
        wr(A_BAUDDIV, 32'd0);
        wr(A_CTRL, 32'h1);
        repeat (120) @(negedge clk);
        rd_expect("t3_drained", A_STATUS, 32'h0000_0004);

        // 4: two queued frames, one idle cycle between, then irq
        wr(A_CTRL, 32'h0);
        wr(A_TXDATA, 32'hFF);
        wr(A_TXDATA, 32'h00);
        wr(A_BAUDDIV, 32'd3);
        wr(A_CTRL, 32'h3);
        wait_fall("t4_first_start");
        gap = 0; prev = 1'b0; found = 1'b0;
        for (int i = 1; i < 100 && !found; i++) begin
            @(negedge clk);
            if (tx == 1'b0 && prev == 1'b1) begin found = 1'b1; gap = i; end
            prev = tx;
        end
        check("t4_frame_spacing", 32'(gap), 32'd41);
        offs = 0; found = 1'b0;
        for (int i = 1; i < 100 && !found; i++) begin
            @(negedge clk);
            if (irq == 1'b1) begin found = 1'b1; offs = i; end
        end
        check("t4_irq_rise", 32'(offs), 32'd41);
        repeat (10) @(negedge clk);
        check("t4_irq_hold", 32'(irq), 32'h1);
        wr(A_TXDATA, 32'h5A);
        check("t4_irq_still_at_ack", 32'(irq), 32'h1);
        @(negedge clk);
        check("t4_irq_cleared", 32'(irq), 32'h0);
        repeat (45) @(negedge clk);

        // 5: misaligned access, back-to-back reads, byte-lane write
        xfer(1'b0, 32'h0000_8022, 32'h0, 4'hF);
        check("t5_mis_err", 32'(a_err), 32'h1);
        check("t5_mis_ack", 32'(a_ack), 32'h0);
        check("t5_mis_dat", a_dat, 32'h0);
        @(negedge clk);
        bus_drive(1'b0, A_BAUDDIV, 32'h0, 4'hF);
        @(negedge clk);
        check("t5_b2b_ack0", 32'(bus.wb_ack_o), 32'h1);
        check("t5_b2b_dat0", bus.wb_dat_o, 32'h3);
        bus_drive(1'b0, A_CTRL, 32'h0, 4'hF);
        @(negedge clk);
        check("t5_b2b_ack1", 32'(bus.wb_ack_o), 32'h1);
        check("t5_b2b_dat1", bus.wb_dat_o, 32'h3);
        bus_idle();
        xfer(1'b1, A_BAUDDIV, 32'h0000_ABCD, 4'h1);
        rd_expect("t5_lane", A_BAUDDIV, 32'h0000_00CD);
        wr(A_BAUDDIV, 32'd3);
        rd_expect("t5_status_idle", A_STATUS, 32'h0000_0004);

        // 6: reset mid-frame
        wr(A_CTRL, 32'h1);
        wr(A_TXDATA, 32'h00);
        repeat (8) @(negedge clk);
        check("t6_in_data_low", 32'(tx), 32'h0);
        #2 rst = 1'b1;
        #1 check("t6_async_tx", 32'(tx), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_expect("t6_status", A_STATUS, 32'h0000_0004);
        rd_expect("t6_bauddiv", A_BAUDDIV, 32'h0000_0363);
        rd_expect("t6_ctrl", A_CTRL, 32'h0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
